int_to_float_fp32: RTL and testbench
====================================

// Module: int_to_float_fp32
// PURPOSE
//  Pipelined 32-bit integer -> IEEE-754 binary32 converter; inverse of the fp32->int unit in the ML datapath.
//  Feeds integer accumulator results back into fp32 compute lanes.
//  Fixed latency 5, one conversion per cycle.
//  Global enable for backpressure; valid bit travels with the data.
// PARAMETERS
//  SIGNED  1  1: in_data is two's complement; 0: in_data is unsigned
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   reset, synchronous, active-high
//  en         in   1   pipeline advance; 0 = every stage holds
//  in_valid   in   1   in_data valid this cycle (sampled only when en=1)
//  in_data    in   32  integer operand
//  out_valid  out  1   out_data valid
//  out_data   out  32  binary32 result {sign, exp[7:0], frac[22:0]}
// BEHAVIOUR
//  Reset:
//  - rst=1 at posedge clears all stage valids and data regs.
//  - out_valid=0, out_data=32'h0.
//  - Reset mid-operation discards in-flight items; no partial output.
//  Advance and latency:
//  - en=1: all 5 stages shift together.
//  - Item sampled at edge N (en=1) appears on out_valid/out_data after edge N+5, provided en=1 on all 5 edges.
//  - en=0 edges do not count toward latency.
//  - en=0: every reg incl. out_valid/out_data holds; in_valid is ignored.
//  - Bubbles (in_valid=0) propagate as out_valid=0. Data regs may update on bubbles; only valid-qualified data is meaningful.
//  Stages:
//  - S1: sign = SIGNED & in_data[31]; mag = sign ? -in_data : in_data (32b unsigned).
//    -2^31 yields mag = 32'h8000_0000.
//  - S2: lz = lzc32(mag), 6b, 0..32; zero flag = (mag==0).
//  - S3: norm = mag << lz (32b); exp = 158 - lz (8b).
//  - S4: frac = norm[30:8]; g = norm[7]; s = |norm[6:0]; round per CONFIGURATION.
//    Mantissa carry-out (frac all ones + 1) -> frac=0, exp+1.
//  - S5: pack.
//    - zero: out_data = 32'h0000_0000. Never -0.
//    - Otherwise {sign, exp, frac}.
//  Range: no overflow/inf/NaN possible. Max exp 158 = 2^31 (+1 after rounding of 0xFFFF_FFFF unsigned).
// CONFIGURATION
//  I2F_ROUND_RNE_EN defined:
//  - Round-to-nearest-even; round up when g & (s | frac[0]).
//  I2F_ROUND_RNE_EN undefined:
//  - Truncate toward zero in magnitude; g/s ignored, no carry path.
//  - Latency stays 5; S4 is a pass-through reg.
// STRUCTURE
//  Package i2f_pkg:
//  - FP32_BIAS=127, I2F_EXP_OFS=158 (bias+31), FP32_FRAC_W=23, FP32_EXP_W=8.
//  - Typedef fp32_t: packed struct {sign, exp, frac}.
//  Sub-module lzc32:
//  - Combinational 32b leading-zero counter, 6b out, 32 for zero input.
//  - Instantiated in S2; separately unit-tested.
// TESTING
//  - Basic: in 32'd1 -> 32'h3F80_0000; 32'hFFFF_FFFF (SIGNED=1) -> 32'hBF80_0000; 0 -> 32'h0000_0000; each out_valid exactly 5 cycles later.
//  - Extremes, SIGNED=1: 32'h8000_0000 -> 32'hCF00_0000; 32'h7FFF_FFFF -> 32'h4F00_0000 (RNE) / 32'h4EFF_FFFF (trunc).
//  - Tie cases: 32'd16777217 -> 32'h4B80_0000 (tie to even, both modes); 32'd16777219 -> 32'h4B80_0002 (RNE) / 32'h4B80_0001 (trunc).
//  - Unsigned, SIGNED=0: 32'hFFFF_FFFF -> 32'h4F80_0000 (RNE carry into exponent) / 32'h4F7F_FFFF (trunc).
//  - Back-to-back stream of 100 random values, en toggled randomly:
//    - outputs in order and match the reference model;
//    - en=0 freezes out_valid/out_data;
//    - no drops, no duplicates.
//  - rst asserted for 1 cycle with 3 items in flight: out_valid=0 next cycle and stays 0 until new in_valid items complete 5 en-cycles later.

Source files
------------

// File: rtl/i2f_pkg.sv
// rtl/i2f_pkg.sv - shared constants and binary32 layout for the int->fp32 converter
package i2f_pkg;

    localparam int FP32_BIAS   = 127;
    localparam int I2F_EXP_OFS = FP32_BIAS + 31;
    localparam int FP32_FRAC_W = 23;
    localparam int FP32_EXP_W  = 8;

    typedef struct packed {
        logic                   sign;
        logic [FP32_EXP_W-1:0]  exp;
        logic [FP32_FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational 32-bit leading-zero counter, 32 for an all-zero word
module lzc32 (
    input  logic [31:0] data_i,
    output logic [5:0]  lz_o
);

    // Ascending scan so the highest set bit is the last (and winning) assignment.
    always_comb begin
        lz_o = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (data_i[i]) begin
                lz_o = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_float_fp32.sv
// rtl/int_to_float_fp32.sv - 5-stage int32 -> binary32 converter; I2F_ROUND_RNE_EN selects RNE over truncation
module int_to_float_fp32
    import i2f_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    output logic [31:0] out_data
);

    // Truncation never looks below the kept fraction, so those bits are not carried into S3.
`ifdef I2F_ROUND_RNE_EN
    localparam int NORM_LSB = 0;
`else
    localparam int NORM_LSB = 8;
`endif
    localparam int NORM_W = 31 - NORM_LSB;

    // Sampling register: the operand captured on an enabled edge.
    logic        v0_q;
    logic [31:0] data0_q;
    // S1: sign / magnitude
    logic        v1_q, sign1_q, sign1_d;
    logic [31:0] mag1_q, mag1_d;
    // S2: leading-zero count
    logic        v2_q, sign2_q, zero2_q;
    logic [31:0] mag2_q;
    logic [5:0]  lz2_q, lz2_d;
    // S3: normalise; the implicit leading one (bit 31) is dropped
    logic              v3_q, sign3_q, zero3_q;
    logic [30:NORM_LSB] norm3_q;
    logic [NORM_W-1:0]  norm3_d;
    logic [7:0]         exp3_q, exp3_d;
    // S4: round
    logic        v4_q, sign4_q, zero4_q;
    logic [7:0]  exp4_q, exp4_d;
    logic [22:0] frac4_q, frac4_d;
    // S5: packed result
    logic        out_valid_q;
    fp32_t       out_q, out_d;

    lzc32 u_lzc (
        .data_i (mag1_q),
        .lz_o   (lz2_d)
    );

    // Per-stage datapath between the pipeline registers.
    always_comb begin
        sign1_d = SIGNED & data0_q[31];
        mag1_d  = sign1_d ? (32'd0 - data0_q) : data0_q;

        norm3_d = NORM_W'((mag2_q << lz2_q) >> NORM_LSB);
        exp3_d  = 8'(I2F_EXP_OFS - int'(lz2_q));

`ifdef I2F_ROUND_RNE_EN
        begin
            logic        round_up;
            logic [23:0] frac_sum;
            round_up = norm3_q[7] & ((|norm3_q[6:0]) | norm3_q[8]);
            frac_sum = {1'b0, norm3_q[30:8]} + 24'(round_up);
            frac4_d  = frac_sum[22:0];
            exp4_d   = exp3_q + 8'(frac_sum[23]);
        end
`else
        frac4_d = norm3_q[30:8];
        exp4_d  = exp3_q;
`endif

        out_d = '0;
        if (!zero4_q) begin
            out_d.sign = sign4_q;
            out_d.exp  = exp4_q;
            out_d.frac = frac4_q;
        end
    end

    // Pipeline registers: reset clears everything, en=0 freezes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q        <= 1'b0;
            data0_q     <= '0;
            v1_q        <= 1'b0;
            sign1_q     <= 1'b0;
            mag1_q      <= '0;
            v2_q        <= 1'b0;
            sign2_q     <= 1'b0;
            zero2_q     <= 1'b0;
            mag2_q      <= '0;
            lz2_q       <= '0;
            v3_q        <= 1'b0;
            sign3_q     <= 1'b0;
            zero3_q     <= 1'b0;
            norm3_q     <= '0;
            exp3_q      <= '0;
            v4_q        <= 1'b0;
            sign4_q     <= 1'b0;
            zero4_q     <= 1'b0;
            exp4_q      <= '0;
            frac4_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (en) begin
            v0_q        <= in_valid;
            data0_q     <= in_data;
            v1_q        <= v0_q;
            sign1_q     <= sign1_d;
            mag1_q      <= mag1_d;
            v2_q        <= v1_q;
            sign2_q     <= sign1_q;
            zero2_q     <= (mag1_q == 32'd0);
            mag2_q      <= mag1_q;
            lz2_q       <= lz2_d;
            v3_q        <= v2_q;
            sign3_q     <= sign2_q;
            zero3_q     <= zero2_q;
            norm3_q     <= norm3_d;
            exp3_q      <= exp3_d;
            v4_q        <= v3_q;
            sign4_q     <= sign3_q;
            zero4_q     <= zero3_q;
            exp4_q      <= exp4_d;
            frac4_q     <= frac4_d;
            out_valid_q <= v4_q;
            out_q       <= out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_q;

endmodule

// File: tb/tb_int_to_float_fp32.sv
// tb/tb_int_to_float_fp32.sv - self-checking bench for int_to_float_fp32 (both signedness builds) and lzc32
module tb_int_to_float_fp32;

    logic        clk = 1'b0;
    logic        rst, en, in_valid;
    logic [31:0] in_data;
    logic        out_valid_s, out_valid_u;
    logic [31:0] out_data_s, out_data_u;
    logic [31:0] lz_in;
    logic [5:0]  lz_out;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef I2F_ROUND_RNE_EN
    localparam logic [31:0] EXP_7FFF   = 32'h4F00_0000;
    localparam logic [31:0] EXP_TIE3   = 32'h4B80_0002;
    localparam logic [31:0] EXP_FFFF_U = 32'h4F80_0000;
`else
    localparam logic [31:0] EXP_7FFF   = 32'h4EFF_FFFF;
    localparam logic [31:0] EXP_TIE3   = 32'h4B80_0001;
    localparam logic [31:0] EXP_FFFF_U = 32'h4F7F_FFFF;
`endif

    always #5 clk = ~clk;

    int_to_float_fp32 #(.SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_s), .out_data(out_data_s)
    );

    int_to_float_fp32 #(.SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid_u), .out_data(out_data_u)
    );

    lzc32 u_lzc (.data_i(lz_in), .lz_o(lz_out));

    // Items in flight: expected results plus the number of enabled edges since sampling.
    typedef struct {
        logic [31:0] es;
        logic [31:0] eu;
        int          age;
    } item_t;
    item_t       q[$];
    logic [31:0] prev_s, prev_u;
    int          n_out;

    // Reference conversion from the numeric value: find the exponent, keep 24 significant bits, round.
    function automatic logic [31:0] ref_fp(input logic [31:0] d, input bit sgn);
        longint v, a, m;
        int     e, sh;
        bit     neg;
        v = sgn ? longint'($signed(d)) : longint'({32'b0, d});
        if (v == 0) return 32'h0;
        neg = (v < 0);
        a   = neg ? -v : v;
        e   = 0;
        while ((a >> (e + 1)) != 0) e++;
        if (e <= 23) begin
            m = a << (23 - e);
        end else begin
            sh = e - 23;
            m  = a >> sh;
`ifdef I2F_ROUND_RNE_EN
            begin
                longint rem, half;
                rem  = a - (m << sh);
                half = longint'(1) << (sh - 1);
                if (rem > half || (rem == half && m[0])) m++;
                if (m == (longint'(1) << 24)) begin
                    m = m >> 1;
                    e++;
                end
            end
`endif
        end
        return {neg, 8'(e + 127), m[22:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: drive inputs mid-cycle, advance the model on the edge, check just after it.
    task automatic step(input bit r, input bit e, input bit iv, input logic [31:0] d);
        bit expv;
        @(negedge clk);
        rst = r; en = e; in_valid = iv; in_data = d;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            chk("rst_valid_s", 32'(out_valid_s), 32'd0);
            chk("rst_valid_u", 32'(out_valid_u), 32'd0);
            chk("rst_data_s", out_data_s, 32'h0);
            chk("rst_data_u", out_data_u, 32'h0);
        end else begin
            if (e) begin
                while (q.size() > 0 && q[0].age >= 5) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (iv) q.push_back('{es: ref_fp(d, 1'b1), eu: ref_fp(d, 1'b0), age: 0});
            end
            expv = (q.size() > 0 && q[0].age == 5);
            chk("valid_s", 32'(out_valid_s), 32'(expv));
            chk("valid_u", 32'(out_valid_u), 32'(expv));
            if (expv) begin
                chk("data_s", out_data_s, q[0].es);
                chk("data_u", out_data_u, q[0].eu);
            end
            if (!e) begin
                chk("hold_s", out_data_s, prev_s);
                chk("hold_u", out_data_u, prev_u);
            end
            if (e && out_valid_s) n_out++;
        end
        prev_s = out_data_s;
        prev_u = out_data_u;
    endtask

    // Single item through an otherwise idle pipeline, checked against fixed results.
    task automatic directed(input string tag, input logic [31:0] d,
                            input logic [31:0] es, input logic [31:0] eu);
        step(1'b0, 1'b1, 1'b1, d);
        repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0);
        chk({tag, "_vs"}, 32'(out_valid_s), 32'd1);
        chk({tag, "_s"}, out_data_s, es);
        chk({tag, "_u"}, out_data_u, eu);
    endtask

    initial begin
        logic [31:0] table_v [5];
        logic [31:0] v;
        int          sent, guard;

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; lz_in = '0;
        prev_s = '0; prev_u = '0; n_out = 0;
        table_v[0] = 32'h0;         table_v[1] = 32'h1;
        table_v[2] = 32'hFFFF_FFFF; table_v[3] = 32'h8000_0000;
        table_v[4] = 32'h7FFF_FFFF;

        // Leading-zero counter on its own.
        for (int i = 0; i < 40; i++) begin
            int  r;
            bit  found;
            lz_in = (i == 0) ? 32'h0 : ($urandom | 32'h1) >> (i % 32);
            r = 32;
            found = 1'b0;
            for (int b = 31; b >= 0; b--) begin
                if (!found && lz_in[b]) begin
                    r = 31 - b;
                    found = 1'b1;
                end
            end
            #1;
            chk("lzc", 32'(lz_out), 32'(r));
        end

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h5);

        directed("one",      32'd1,           32'h3F80_0000, 32'h3F80_0000);
        directed("minus1",   32'hFFFF_FFFF,   32'hBF80_0000, EXP_FFFF_U);
        directed("zero",     32'd0,           32'h0000_0000, 32'h0000_0000);
        directed("min_int",  32'h8000_0000,   32'hCF00_0000, 32'h4F00_0000);
        directed("max_int",  32'h7FFF_FFFF,   EXP_7FFF,      EXP_7FFF);
        directed("tie_even", 32'd16777217,    32'h4B80_0000, 32'h4B80_0000);
        directed("tie_odd",  32'd16777219,    EXP_TIE3,      EXP_TIE3);

        // Random stream with random backpressure and bubbles.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        n_out = 0;
        sent  = 0;
        guard = 0;
        while (sent < 100 && guard < 2000) begin
            bit e, iv;
            guard++;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = $urandom >> $urandom_range(0, 31);
                2: v = 32'd0 - ($urandom >> $urandom_range(0, 31));
                default: v = table_v[$urandom_range(0, 4)];
            endcase
            e  = ($urandom_range(0, 3) != 0);
            iv = ($urandom_range(0, 4) != 0);
            step(1'b0, e, iv, v);
            if (e && iv) sent++;
        end
        guard = 0;
        while (q.size() > 0 && !(q.size() == 1 && q[0].age == 5) && guard < 60) begin
            guard++;
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end
        chk("stream_drained", 32'(guard < 60), 32'd1);
        chk("stream_count", 32'(n_out), 32'(sent));

        // Reset with three items in flight, then a fresh item.
        step(1'b0, 1'b1, 1'b1, 32'd7);
        step(1'b0, 1'b1, 1'b1, 32'd9);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, i[0], 1'b0, 32'h0);
        directed("after_rst", 32'd1, 32'h3F80_0000, 32'h3F80_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
